// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and byte-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StMerge,
    StResp
  } lsu_state_e;

  // Bit offset of little-endian byte lane within a 32-bit word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

  // Bit offset of the halfword containing the given lane.
  function automatic logic [4:0] half_lsb(input logic [1:0] lane);
    return {lane[1], 4'b0000};
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Combinational byte/halfword lane logic: load extraction with extension,
// sub-word store merge, and width/alignment fault detection.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  input  logic        write_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o,
  output logic        fault_o
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_off = lane_lsb(lane_i);
  assign half_off = half_lsb(lane_i);
  assign byte_sel = word_i[byte_off +: LANE_W];
  assign half_sel = word_i[half_off +: HALF_W];

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'b0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'b0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    if (funct3_i == F3_B) begin
      merge_o[byte_off +: LANE_W] = wdata_i[7:0];
    end else if (funct3_i == F3_H) begin
      merge_o[half_off +: HALF_W] = wdata_i;
    end
  end

  // Unsigned widths are load-only; reserved codes always fault.
  always_comb begin
    fault_o = 1'b1;
    case (funct3_i)
      F3_B:    fault_o = 1'b0;
      F3_BU:   fault_o = write_i;
      F3_H:    fault_o = lane_i[0];
      F3_HU:   fault_o = lane_i[0] | write_i;
      F3_W:    fault_o = |lane_i;
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory;
// adds sub-word access via extension and read-modify-write merge.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q;
  logic [31:0] rdata_q;
  logic        resp_valid_q;
  logic        err_q;
  logic [31:0] word_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic [31:0] lu_word;
  logic [1:0]  lu_lane;
  logic [2:0]  lu_funct3;
  logic        lu_write;
  logic [15:0] lu_wdata;
  logic [31:0] lu_load;
  logic [31:0] lu_merge;
  logic        lu_fault;
  logic        out_of_range;
  logic        fault;

  // Lane unit sees the live request in IDLE and the captured one in MERGE.
  always_comb begin
    if (state_q == StMerge) begin
      lu_word   = word_q;
      lu_lane   = addr_q[1:0];
      lu_funct3 = funct3_q;
      lu_write  = 1'b1;
      lu_wdata  = wdata_q[15:0];
    end else begin
      lu_word   = mem_rdata_i;
      lu_lane   = addr_i[1:0];
      lu_funct3 = funct3_i;
      lu_write  = req_write_i;
      lu_wdata  = wdata_i[15:0];
    end
  end

  lsu_lane_unit u_lane (
    .word_i   (lu_word),
    .lane_i   (lu_lane),
    .funct3_i (lu_funct3),
    .write_i  (lu_write),
    .wdata_i  (lu_wdata),
    .load_o   (lu_load),
    .merge_o  (lu_merge),
    .fault_o  (lu_fault)
  );

  assign out_of_range = {2'b00, addr_i[31:2]} >= MEM_WORDS;
  assign fault        = lu_fault | out_of_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      word_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            err_q    <= fault;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            funct3_q <= funct3_i;
            if (!fault && req_write_i && funct3_i != F3_W) begin
              // Registered so the read path never chains into the write data.
              word_q  <= mem_rdata_i;
              state_q <= StMerge;
            end else begin
              if (!fault && !req_write_i) begin
                rdata_q <= lu_load;
              end
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end
          end
        end
        StMerge: begin
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_we_o    = 1'b0;
    case (state_q)
      StIdle: begin
        mem_addr_o  = addr_i;
        mem_wdata_o = wdata_i;
        mem_we_o    = req_valid_i & req_write_i & (funct3_i == F3_W) & ~fault;
      end
      StMerge: begin
        mem_wdata_o = lu_merge;
        mem_we_o    = 1'b1;
      end
      default: ;
    endcase
    // Abort any write the instant reset rises.
    if (rst) begin
      mem_we_o = 1'b0;
    end
  end

  assign ready_o      = (state_q == StIdle);
  assign resp_valid_o = resp_valid_q;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the test plan,
// a mid-merge reset, then randomized traffic against a byte-level memory model.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 16000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .ready_o      (ready),
    .resp_valid_o (resp_valid),
    .rdata_o      (rdata),
    .err_o        (err),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_we_o     (mem_we),
    .mem_rdata_i  (mem_rdata)
  );

  // Data memory: asynchronous read, synchronous write, preloaded on first edge.
  logic [31:0] mem [MEM_WORDS];
  bit          mem_loaded = 1'b0;

  assign mem_rdata = (mem_addr[31:2] < 30'(MEM_WORDS)) ? mem[mem_addr[31:2]] : 32'hDEAD_DEAD;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
      mem[16]    <= 32'h8070_F0A5;
      mem_loaded <= 1'b1;
    end else if (mem_we && mem_addr[31:2] < 30'(MEM_WORDS)) begin
      mem[mem_addr[31:2]] <= mem_wdata;
    end
  end

  // Reference model state and per-transaction expectations.
  logic [31:0] model_mem [MEM_WORDS];
  logic [31:0] last_rdata = '0;
  logic [31:0] e_rdata = '0;
  logic        e_err = 1'b0;
  logic [31:0] e_wword = '0;
  logic [31:0] e_waddr = '0;
  int          e_lat = 1;
  int          e_we_cyc = -1;

  int checks = 0;
  int failures = 0;
  int issued = 0;
  int completed = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Byte-granular model of one access; updates the model memory for stores.
  task automatic model_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    int          size;
    int          off;
    logic [31:0] idx;
    logic [31:0] w;
    logic [31:0] mask;
    logic [31:0] val;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    idx  = a >> 2;
    e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]) ||
            (off % size != 0) || (idx >= MEM_WORDS);
    e_lat    = 1;
    e_we_cyc = -1;
    if (!e_err) begin
      w = model_mem[idx];
      if (!wr) begin
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (w >> (8 * off)) & mask;
        if (!f3[2] && val[8 * size - 1]) val = val | ~mask;
        last_rdata = val;
      end else begin
        for (int i = 0; i < size; i++) w[8 * (off + i) +: 8] = wd[8 * i +: 8];
        model_mem[idx] = w;
        e_wword  = w;
        e_waddr  = a;
        e_we_cyc = (size == 4) ? 0 : 1;
        e_lat    = (size == 4) ? 1 : 2;
      end
    end
    e_rdata = last_rdata;
  endtask

  // Single compare process: every falling edge, DUT outputs vs expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      if (issued != completed) begin
        chk("ready", 32'(ready), 32'(cyc == 0));
        chk("resp_valid", 32'(resp_valid), 32'(cyc == e_lat));
        chk("mem_we", 32'(mem_we), 32'(cyc == e_we_cyc));
        if (mem_we && cyc == e_we_cyc) begin
          chk("mem_wdata", mem_wdata, e_wword);
          chk("mem_addr", mem_addr & ~32'h3, e_waddr & ~32'h3);
        end
        if (cyc == e_lat) begin
          chk("rdata", rdata, e_rdata);
          chk("err", 32'(err), 32'(e_err));
          completed++;
          cyc = 0;
        end else begin
          cyc++;
        end
      end else begin
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
      end
    end
  end

  task automatic run(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
    @(posedge clk);
    #1;
    model_txn(wr, f3, a, wd);
    req_valid = 1'b1;
    req_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    issued++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && completed != issued; i++) begin
      @(negedge clk);
      #1;
    end
    if (completed != issued) begin
      failures++;
      $display("FAIL timeout: no response for addr 0x%08h funct3 %0d", a, f3);
      finish_tb();
    end
  endtask

  logic [2:0] f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) model_mem[i] = '0;
    model_mem[16] = 32'h8070_F0A5;

    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    run(1'b0, 3'd0, 32'h41, 32'h0);
    chk("lit_lb", rdata, 32'hFFFF_FFF0);
    chk("model_lb", last_rdata, 32'hFFFF_FFF0);
    chk("lit_lb_err", 32'(err), 32'd0);
    run(1'b0, 3'd4, 32'h41, 32'h0);
    chk("lit_lbu", rdata, 32'h0000_00F0);
    run(1'b0, 3'd1, 32'h42, 32'h0);
    chk("lit_lh", rdata, 32'hFFFF_8070);
    run(1'b0, 3'd5, 32'h42, 32'h0);
    chk("lit_lhu", rdata, 32'h0000_8070);
    run(1'b0, 3'd2, 32'h40, 32'h0);
    chk("lit_lw", rdata, 32'h8070_F0A5);

    run(1'b1, 3'd0, 32'h43, 32'h1234_5611);
    chk("lit_sb_mem", mem[16], 32'h1170_F0A5);
    chk("model_sb", model_mem[16], 32'h1170_F0A5);
    run(1'b0, 3'd2, 32'h40, 32'h0);
    chk("lit_sb_readback", rdata, 32'h1170_F0A5);
    run(1'b1, 3'd1, 32'h40, 32'hDEAD_BEEF);
    chk("lit_sh_mem", mem[16], 32'h1170_BEEF);
    run(1'b1, 3'd2, 32'h44, 32'hCAFE_BABE);
    run(1'b0, 3'd2, 32'h44, 32'h0);
    chk("lit_sw_readback", rdata, 32'hCAFE_BABE);

    run(1'b0, 3'd2, 32'h42, 32'h0);
    chk("lit_fault_lw_err", 32'(err), 32'd1);
    chk("lit_fault_lw_rdata", rdata, 32'hCAFE_BABE);
    run(1'b1, 3'd1, 32'h41, 32'h5555_5555);
    chk("lit_fault_sh_err", 32'(err), 32'd1);
    chk("lit_fault_sh_mem", mem[16], 32'h1170_BEEF);
    run(1'b0, 3'd3, 32'h40, 32'h0);
    chk("lit_fault_f3_err", 32'(err), 32'd1);
    run(1'b0, 3'd2, 32'h0000_FA00, 32'h0);
    chk("lit_fault_range_err", 32'(err), 32'd1);
    chk("lit_fault_range_rdata", rdata, 32'hCAFE_BABE);

    // Reset asserted while the sb merge write is presented.
    @(posedge clk);
    #1;
    chk_en    = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    funct3    = 3'd0;
    addr      = 32'h40;
    wdata     = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("merge_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_abort_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    chk("rst_abort_mem", mem[16], model_mem[16]);
    chk("rst_abort_ready", 32'(ready), 32'd1);
    chk("rst_abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_abort_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r == 0)      a = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 15));
      else if (r == 1) a = 32'((MEM_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      else             a = 32'h40 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else                           f3 = f3_tab[$urandom_range(0, 4)];
      run(1'($urandom_range(0, 1)), f3, a, $urandom());
    end

    for (int i = 16; i < 24; i++) chk("final_mem", mem[i], model_mem[i]);
    chk("final_top_word", mem[MEM_WORDS - 1], model_mem[MEM_WORDS - 1]);
    finish_tb();
  end

endmodule
